// File: rtl/pc_fetch_ctrl.sv
// Instruction fetch controller: owns F_PC, issues one imem request per instruction
// and hands F_PC/F_instr to decode. Optional fetch address check via FETCH_ADEL_CHECK_EN.
module pc_fetch_ctrl #(
    parameter logic [31:0] RESET_PC   = 32'h0000_3000,
    parameter logic [31:0] EXC_VECTOR = 32'h0000_4180
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] next_pc,
    input  logic        stall,
    input  logic        exc_req,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] F_PC,
    output logic [31:0] F_instr,
    output logic        F_valid,
    output logic        F_exc_adel
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        READY = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [31:0] r_pc;
    logic [31:0] w_pc_next;
    logic [31:0] r_instr;
    logic [31:0] w_instr_next;
    logic        r_adel;
    logic        w_adel_next;
    logic        w_adel_err;

`ifdef FETCH_ADEL_CHECK_EN
    assign w_adel_err = (r_pc[1:0] != 2'b00) || (r_pc < 32'h0000_3000) || (r_pc > 32'h0000_6FFC);
`else
    assign w_adel_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_pc    <= RESET_PC;
            r_instr <= 32'h0;
            r_adel  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_pc    <= w_pc_next;
            r_instr <= w_instr_next;
            r_adel  <= w_adel_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_pc_next    = r_pc;
        w_instr_next = r_instr;
        w_adel_next  = r_adel;
        case (r_state)
            IDLE: begin
                w_state_next = FETCH;
            end
            FETCH: begin
                if (exc_req) begin
                    // A request still in flight must complete before the redirect.
                    if (imem_ack || w_adel_err) begin
                        w_pc_next = EXC_VECTOR;
                    end else begin
                        w_state_next = DRAIN;
                    end
                end else if (w_adel_err) begin
                    w_instr_next = 32'h0;
                    w_adel_next  = 1'b1;
                    w_state_next = READY;
                end else if (imem_ack) begin
                    w_instr_next = imem_rdata;
                    w_adel_next  = 1'b0;
                    w_state_next = READY;
                end
            end
            DRAIN: begin
                if (imem_ack) begin
                    w_pc_next    = EXC_VECTOR;
                    w_state_next = FETCH;
                end
            end
            READY: begin
                if (exc_req) begin
                    w_pc_next    = EXC_VECTOR;
                    w_state_next = FETCH;
                end else if (!stall) begin
                    w_pc_next    = next_pc;
                    w_state_next = FETCH;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    assign imem_req   = ((r_state == FETCH) && !w_adel_err) || (r_state == DRAIN);
    assign imem_addr  = r_pc;
    assign F_PC       = r_pc;
    assign F_instr    = r_instr;
    assign F_valid    = (r_state == READY);
    assign F_exc_adel = r_adel;

endmodule
